// File: rtl/rx_fetch_ctrl.sv
// rx_fetch_ctrl: host-side fetch controller for the UART receive engine.
// Reads each ready byte plus its error flags into a FIFO and counts errors and drops.
module rx_fetch_ctrl #(
  parameter int         DEPTH        = 8,
  parameter logic [3:0] DATA_PORT    = 4'h0,
  parameter bit         DROP_ON_FULL = 1'b0,
  parameter int         CNT_W        = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     rx_rdy,
  input  logic                     rx_perr,
  input  logic                     rx_ferr,
  input  logic                     rx_ovf,
  input  logic [7:0]               uart_data,
  output logic [3:0]               port_id,
  output logic                     read_strobe,
  output logic [7:0]               dout,
  output logic [2:0]               dout_err,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         err_cnt,
  input  logic                     cnt_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SAT_C = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [10:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              full, empty;
  logic              push, pop, drop, err_inc;
  logic [2:0]        flags;

  assign flags = {rx_ovf, rx_ferr, rx_perr};
  assign full  = (cnt_q == FULL_C);
  assign empty = (cnt_q == '0);

  // Fullness is judged at the start of the READ cycle; a same-cycle pop does not make room.
  assign push    = (state_q == READ) && !full;
  assign drop    = (state_q == READ) && full;
  assign pop     = !empty && dout_ready;
  assign err_inc = (push && (flags != 3'b000)) || drop;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rx_rdy && (!full || DROP_ON_FULL)) begin
          state_d = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        if (!rx_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_strobe = 1'b0;
    port_id     = 4'hF;
    unique case (state_q)
      READ: begin
        read_strobe = 1'b1;
        port_id     = DATA_PORT;
      end
      WAIT:    port_id = DATA_PORT;
      default: port_id = 4'hF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {flags, uart_data};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (cnt_clr) begin
      err_d = '0;
    end else if (err_inc && (err_q != SAT_C)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign dout       = mem_q[rd_ptr_q][7:0];
  assign dout_err   = mem_q[rd_ptr_q][10:8];
  assign dout_valid = !empty;
  assign fifo_count = cnt_q;
  assign err_cnt    = err_q;

endmodule
